// File: rtl/uart_keycode_rx.sv
// Keycode link receiver: pops UART RX FIFO bytes, hunts for HEADER, rebuilds {hi,lo},
// checks the XOR checksum and holds the keycode until the next good frame or link silence.
module uart_keycode_rx #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 650_000,
  parameter int unsigned RELEASE_CYCLES = 6_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_empty,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  output logic [15:0] keycode,
  output logic        keycode_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {HUNT, HI, LO, CHK} state_t;

  state_t           state;
  logic [7:0]       byte_q;
  logic [7:0]       hi_q;
  logic [7:0]       lo_q;
  logic [TO_W-1:0]  to_cnt;
  logic [REL_W-1:0] rel_cnt;

  logic pop_c;
  logic to_hit_c;
  logic sum_ok_c;
  logic in_frame_c;

  // rd_uart high in the previous cycle forces the bubble while the FIFO flags catch up
  assign pop_c    = !rx_empty && !rd_uart;
  // a fresh pop in the expiry cycle keeps the frame alive
  assign to_hit_c = (state != HUNT) && !rd_uart && !pop_c && (to_cnt == TO_LAST);
  assign sum_ok_c = (byte_q == (HEADER ^ hi_q ^ lo_q));

  // whether the inter-byte timer keeps running after this edge
  always_comb begin
    in_frame_c = (state != HUNT) && !to_hit_c;
    if (rd_uart) begin
      case (state)
        HUNT:    in_frame_c = (byte_q == HEADER);
        CHK:     in_frame_c = 1'b0;
        default: in_frame_c = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HUNT;
      byte_q        <= 8'h00;
      hi_q          <= 8'h00;
      lo_q          <= 8'h00;
      to_cnt        <= '0;
      rel_cnt       <= '0;
      rd_uart       <= 1'b0;
      keycode       <= 16'h0000;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
      err_cnt       <= 8'h00;
    end else begin
      rd_uart       <= pop_c;
      keycode_valid <= 1'b0;
      frame_err     <= 1'b0;
      if (pop_c) begin
        byte_q <= r_data;
      end

      if (pop_c) begin
        to_cnt <= '0;
      end else if (in_frame_c) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end

      // link-silence release; a good frame below overrides both assignments
      if (rel_cnt == REL_LAST) begin
        keycode <= 16'h0000;
      end else begin
        rel_cnt <= rel_cnt + REL_W'(1);
      end

      if (rd_uart) begin
        case (state)
          HUNT: begin
            if (byte_q == HEADER) begin
              state <= HI;
            end
          end
          HI: begin
            hi_q  <= byte_q;
            state <= LO;
          end
          LO: begin
            lo_q  <= byte_q;
            state <= CHK;
          end
          CHK: begin
            state <= HUNT;
            if (sum_ok_c) begin
              keycode       <= {hi_q, lo_q};
              keycode_valid <= 1'b1;
              rel_cnt       <= '0;
            end else begin
              frame_err <= 1'b1;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end else if (to_hit_c) begin
        state     <= HUNT;
        frame_err <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_keycode_rx.sv
// Scoreboard bench for uart_keycode_rx: a frame-buffer reference model predicts good/error
// events, a monitor pops and compares them, and directed checks cover timing boundaries.
module tb_uart_keycode_rx;

  localparam int unsigned TO  = 100;
  localparam int unsigned REL = 1000;
  localparam logic [7:0]  HDR = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  r_data = 8'h00;
  logic        rd_uart;
  logic [15:0] keycode;
  logic        keycode_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;

  uart_keycode_rx #(
    .HEADER        (HDR),
    .TIMEOUT_CYCLES(TO),
    .RELEASE_CYCLES(REL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_empty     (rx_empty),
    .r_data       (r_data),
    .rd_uart      (rd_uart),
    .keycode      (keycode),
    .keycode_valid(keycode_valid),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] kc;
    logic [7:0]  ec;
  } ev_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] fifo[$];
  logic [7:0] push_q[$];
  ev_t        exp_q[$];
  logic [7:0] fbuf[$];
  logic [7:0] m_err = 8'h00;
  int         last_pop_cyc   = -1;
  int         last_valid_cyc = -1;
  int         last_err_cyc   = -1;
  int         n_pops   = 0;
  int         n_errs   = 0;
  int         n_valids = 0;
  bit         rd_seen  = 1'b0;
  bit         prev_rd  = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // reference model: collect a frame as bytes, judge it once four bytes are in
  function automatic void model_err();
    ev_t e;
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    e.is_err = 1'b1;
    e.kc     = 16'h0000;
    e.ec     = m_err;
    exp_q.push_back(e);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    ev_t e;
    if (fbuf.size() == 0) begin
      if (b == HDR) fbuf.push_back(b);
    end else begin
      fbuf.push_back(b);
      if (fbuf.size() == 4) begin
        if (fbuf[3] == (fbuf[0] ^ fbuf[1] ^ fbuf[2])) begin
          e.is_err = 1'b0;
          e.kc     = {fbuf[1], fbuf[2]};
          e.ec     = m_err;
          exp_q.push_back(e);
        end else begin
          model_err();
        end
        fbuf.delete();
      end
    end
  endfunction

  function automatic void model_timeout();
    if (fbuf.size() != 0) begin
      model_err();
      fbuf.delete();
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pops after an rd_uart cycle, accepts new bytes mid-cycle
  always begin
    @(posedge clk);
    #1;
    if (rd_seen && fifo.size() != 0) void'(fifo.pop_front());
    rx_empty = (fifo.size() == 0);
    r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    @(negedge clk);
    #3;
    while (push_q.size() != 0) fifo.push_back(push_q.pop_front());
    rx_empty = (fifo.size() == 0);
    r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // monitor: bubble rule, event exclusivity, scoreboard compare
  always @(negedge clk) begin
    ev_t e;
    rd_seen = rd_uart;
    if (rd_uart) begin
      check("pop_bubble", 32'(prev_rd), 32'd0);
      n_pops++;
      last_pop_cyc = cyc;
    end
    prev_rd = rd_uart;
    if (keycode_valid || frame_err) begin
      check("valid_err_exclusive", 32'(keycode_valid & frame_err), 32'd0);
      if (frame_err) begin
        n_errs++;
        last_err_cyc = cyc;
      end else begin
        n_valids++;
        last_valid_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: valid=%0b err=%0b keycode=%04h err_cnt=%02h, none expected",
                 keycode_valid, frame_err, keycode, err_cnt);
      end else begin
        e = exp_q.pop_front();
        check("event_kind_is_err", 32'(frame_err), 32'(e.is_err));
        if (e.is_err) check("err_cnt", 32'(err_cnt), 32'(e.ec));
        else          check("keycode", 32'(keycode), 32'(e.kc));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    push_q.push_back(b);
    model_byte(b);
    repeat (gap) tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo.size() != 0 || push_q.size() != 0 || rd_uart) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: fifo=%0d still queued, expected 0", fifo.size());
    end
    repeat (3) tick();
  endtask

  task automatic wait_events();
    int n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      tick();
      n++;
    end
    if (n >= 6000) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_events_timeout: %0d events outstanding, expected 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic idle_timeout();
    drain();
    model_timeout();
    repeat (TO + 20) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, p, ne, nv, n;
    logic [7:0] hi, lo, b;

    // reset held with a byte pending
    repeat (3) tick();
    send(HDR, 0);
    repeat (4) tick();
    check("reset_rd_uart", 32'(rd_uart), 32'd0);
    check("reset_keycode", 32'(keycode), 32'd0);
    check("reset_valid", 32'(keycode_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);

    rst = 1'b1;
    c0 = cyc;
    n = 0;
    while (n_pops == 0 && n < 10) begin
      tick();
      n++;
    end
    check("first_pop_within_2", 32'((n_pops > 0) && (last_pop_cyc - c0 <= 2)), 32'd1);

    // good frame A5 00 1C B9
    send(8'h00, 0);
    send(8'h1C, 0);
    send(8'hB9, 0);
    wait_events();
    check("good_pops", 32'(n_pops), 32'd4);
    check("good_valid_latency", 32'(last_valid_cyc - last_pop_cyc), 32'd1);
    check("good_no_err", 32'(n_errs), 32'd0);

    // bad checksum keeps keycode, then a good frame replaces it
    nv = n_valids;
    send(HDR, 0); send(8'h00, 0); send(8'h1C, 0); send(8'h00, 0);
    wait_events();
    check("bad_keycode_held", 32'(keycode), 32'h001C);
    check("bad_no_valid", 32'(n_valids), 32'(nv));
    send(HDR, 0); send(8'hF0, 0); send(8'h1C, 0); send(8'h49, 0);
    wait_events();
    check("after_bad_keycode", 32'(keycode), 32'hF01C);

    // garbage discarded, header value as data
    send(8'h3C, 0); send(8'h7E, 1); send(HDR, 0); send(HDR, 2); send(8'h1C, 0); send(8'h1C, 0);
    wait_events();
    check("garbage_no_err", 32'(err_cnt), 32'd1);
    check("header_as_data", 32'(keycode), 32'hA51C);

    // inter-byte timeout after the second byte
    send(HDR, 0); send(8'h12, 0);
    drain();
    p  = last_pop_cyc;
    ne = n_errs;
    model_timeout();
    n = 0;
    while (n_errs == ne && n < 2 * TO) begin
      tick();
      n++;
    end
    check("timeout_latency", 32'(last_err_cyc - p), 32'(TO));
    send(HDR, 0); send(8'h00, 0); send(8'h1C, 0); send(8'hB9, 0);
    wait_events();
    check("after_timeout_keycode", 32'(keycode), 32'h001C);

    // third byte lands in the expiry cycle: no error
    send(HDR, 0); send(8'h12, 0);
    drain();
    p  = last_pop_cyc;
    ne = n_errs;
    while (cyc < p + int'(TO) - 1) tick();
    send(8'h1C, 0); send(8'hAB, 0);
    wait_events();
    check("expiry_pop_wins", 32'(n_errs), 32'(ne));
    check("expiry_keycode", 32'(keycode), 32'h121C);

    // release after silence
    send(HDR, 0); send(8'h00, 0); send(8'h1C, 0); send(8'hB9, 0);
    wait_events();
    nv = n_valids;
    n = 0;
    while (keycode != 16'h0000 && n < int'(REL) + 50) begin
      tick();
      n++;
    end
    check("release_latency", 32'(cyc - last_valid_cyc), 32'(REL));
    check("release_no_valid", 32'(n_valids), 32'(nv));

    // randomized mix against the reference model
    for (int i = 0; i < 40; i++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          send(HDR, $urandom_range(0, 20)); send(hi, $urandom_range(0, 20));
          send(lo, $urandom_range(0, 20));  send(HDR ^ hi ^ lo, $urandom_range(0, 20));
        end
        1: begin
          send(HDR, $urandom_range(0, 20)); send(hi, $urandom_range(0, 20));
          send(lo, $urandom_range(0, 20));
          send(HDR ^ hi ^ lo ^ 8'($urandom_range(1, 255)), $urandom_range(0, 20));
        end
        2: begin
          b = 8'($urandom);
          if (b == HDR) b = 8'h3C;
          send(b, $urandom_range(0, 20));
        end
        default: begin
          send(HDR, $urandom_range(0, 20));
          n = $urandom_range(0, 2);
          for (int k = 0; k < n; k++) send(8'($urandom), $urandom_range(0, 20));
          idle_timeout();
        end
      endcase
    end
    wait_events();

    // error counter saturation
    ne = n_errs;
    repeat (300) begin
      send(HDR, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    end
    wait_events();
    check("err_cnt_saturated", 32'(err_cnt), 32'hFF);
    check("sat_err_pulses", 32'(n_errs - ne), 32'd300);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
